// File: rtl/axis_fir_infifo.sv
// ---------------------------------------------------------------------------
// axis_fir_infifo
//
// Small synchronous AXI-Stream FIFO that sits between the Wishbone-to-stream
// bridge and the FIR data input. It buffers up to DEPTH words and presents
// the oldest one on the master side. It can also count popped beats to
// generate m_tlast at frame boundaries.
//
// Optional feature macro: AXIS_INFIFO_TLAST_GEN_EN
//   defined   : a 32-bit beat counter drives m_tlast from data_length
//   undefined : no counter, m_tlast is tied to 0, data_length is ignored
//
// Parameters
//   DW    : stream data width in bits
//   DEPTH : number of FIFO entries (power of two, >= 2)
//   AW    : log2(DEPTH)
//
// Ports
//   wb_clk_i    in   1     single clock, all state changes on its rising edge
//   wb_rst_i    in   1     asynchronous active-high reset
//   clear       in   1     synchronous flush of contents and beat counter
//   s_tvalid    in   1     upstream word valid
//   s_tready    out  1     FIFO can accept a word
//   s_tdata     in   DW    upstream word
//   m_tvalid    out  1     word available to the FIR
//   m_tready    in   1     FIR accepts the word
//   m_tdata     out  DW    head-of-FIFO word
//   m_tlast     out  1     head word is the last beat of the frame
//   data_length in   32    frame length in beats (stable during a frame)
//   level       out  AW+1  current occupancy, 0..DEPTH
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A source holding valid keeps its data stable until ready is seen;
// ready never depends combinationally on valid on the same side, so there
// is no valid/ready loop through this block.
// ---------------------------------------------------------------------------
module axis_fir_infifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          clear,
    input  logic          s_tvalid,
    output logic          s_tready,
    input  logic [DW-1:0] s_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tlast,
    input  logic [31:0]   data_length,
    output logic [AW:0]   level
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Storage and pointers. Pointers carry one extra MSB so that full and
    // empty can be told apart when the index bits match.
    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // s_tready is gated by reset so that the upstream sees "not ready" for
    // the whole time reset is held, even before the first clock edge.
    // A full FIFO refuses the word even if a pop happens on the same edge.
    assign s_tready = !full && !wb_rst_i;
    assign m_tvalid = !empty;

    // clear wins over both sides: the beat presented on that edge is lost.
    assign push = s_tvalid && s_tready && !clear;
    assign pop  = m_tvalid && m_tready && !clear;

    // Occupancy falls straight out of the pointer difference; the modulo
    // 2*DEPTH arithmetic gives DEPTH when full and 0 when empty, and it
    // stays put on a simultaneous push and pop.
    assign level = wr_ptr - rd_ptr;

    // Head word comes straight from the array, so it stays stable while the
    // consumer stalls and appears one edge after it was written.
    assign m_tdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Array has no reset: contents are meaningless until the pointers say
    // otherwise, and m_tdata is don't-care while empty.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= s_tdata;
        end
    end

`ifdef AXIS_INFIFO_TLAST_GEN_EN
    // Beat counter: counts words leaving the FIFO within the current frame.
    // data_length of 0 means "no framing": the comparison below can never
    // match, so the counter just free-runs and wraps and m_tlast stays low.
    logic [31:0] beat_cnt;
    logic        frame_end;

    assign frame_end = (data_length != 32'd0) &&
                       (beat_cnt == data_length - 32'd1);
    assign m_tlast   = m_tvalid && frame_end;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            beat_cnt <= 32'd0;
        end else if (clear) begin
            beat_cnt <= 32'd0;
        end else if (pop) begin
            if (frame_end) begin
                beat_cnt <= 32'd0;
            end else begin
                beat_cnt <= beat_cnt + 32'd1;
            end
        end
    end
`else
    // No framing in this build: the frame length input has no load.
    logic unused_data_length;

    assign unused_data_length = ^data_length;
    assign m_tlast            = 1'b0;
`endif

endmodule

// File: doc/axis_fir_infifo.md
AXIS_FIR_INFIFO -- requirements
Module: axis_fir_infifo

Interface
REQ-001 SHALL have parameter DW, default 32, meaning stream data width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, meaning FIFO entries; power of two, minimum 2.
REQ-003 SHALL have parameter AW, default 3, meaning log2(DEPTH).
REQ-004 SHALL have port wb_clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port wb_rst_i  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port clear  in  1  synchronous flush of contents and beat counter.
REQ-007 SHALL have port s_tvalid  in  1  upstream word valid (from the Wishbone-to-stream bridge master side).
REQ-008 SHALL have port s_tready  out  1  FIFO can accept a word.
REQ-009 SHALL have port s_tdata  in  DW  upstream word.
REQ-010 SHALL have port m_tvalid  out  1  word available to the FIR data input.
REQ-011 SHALL have port m_tready  in  1  FIR accepts the word.
REQ-012 SHALL have port m_tdata  out  DW  head-of-FIFO word.
REQ-013 SHALL have port m_tlast  out  1  head word is the last of the frame.
REQ-014 SHALL have port data_length  in  32  frame length in beats; held stable during a frame.
REQ-015 SHALL have port level  out  AW+1  current occupancy, 0..DEPTH.

Function
REQ-016 SHALL push s_tdata when s_tvalid && s_tready; SHALL pop the head word when m_tvalid && m_tready.
REQ-017 SHALL drive s_tready = (level != DEPTH) && !wb_rst_i; no pass-through push when full, even on a simultaneous pop.
REQ-018 SHALL drive m_tvalid = (level != 0); m_tdata SHALL equal the oldest stored word.
REQ-019 SHALL have a latency of one cycle: a word pushed at edge N SHALL be presented with m_tvalid=1 after edge N.
REQ-020 SHALL hold m_tdata and m_tlast stable while m_tvalid=1 and m_tready=0.
REQ-021 SHALL use read and write pointers of AW+1 bits that wrap modulo 2*DEPTH; full when the low bits are equal and the MSBs differ, empty when all bits are equal.
REQ-022 SHALL keep level unchanged on a simultaneous push and pop, increment it on push only, and decrement it on pop only.
REQ-023 SHALL ignore a pop while empty and a push while full; contents and pointers SHALL be unchanged.
REQ-024 SHALL count popped beats in a 32-bit counter; on the pop with counter == data_length-1, the counter SHALL return to 0, else it SHALL increment.
REQ-025 SHALL assert m_tlast = m_tvalid && (counter == data_length-1); with data_length == 0, m_tlast SHALL stay 0 and the counter SHALL free-run.
REQ-026 SHALL zero the pointers, level and counter on clear at the next edge; clear SHALL win over a simultaneous push or pop, and that beat SHALL be dropped.

Reset
REQ-027 SHALL, while wb_rst_i=1, immediately force pointers, level and counter to 0, s_tready=0, m_tvalid=0, m_tlast=0; m_tdata is don't-care.
REQ-028 SHALL treat reset mid-frame as discarding all stored words and the partial-frame count; s_tready=1 on the first cycle after deassertion.

Configuration
REQ-029 SHALL, with macro AXIS_INFIFO_TLAST_GEN_EN defined, implement the beat counter and m_tlast per REQ-024/025.
REQ-030 SHALL, without AXIS_INFIFO_TLAST_GEN_EN, omit the counter, tie m_tlast to 0 and leave data_length unused; all other behaviour is unchanged.

Verification
REQ-031 SHALL cover: reset, then push 0x11 with m_tready=0 -> m_tvalid=1 next cycle, m_tdata=0x11, level=1.
REQ-032 SHALL cover: push 8 words 1..8 with m_tready=0 -> level=8, s_tready=0; ninth push ignored; drain -> 1..8 in order.
REQ-033 SHALL cover: level=4 with continuous push and pop for 20 cycles -> level stays 4, pointers wrap, data order preserved.
REQ-034 SHALL cover: macro defined, data_length=5, stream 10 words -> m_tlast=1 on beats 5 and 10 only; with data_length=0 -> never set.
REQ-035 SHALL cover: level=3 with counter=2, clear asserted together with a push -> level=0, m_tvalid=0, counter=0, pushed word absent.
REQ-036 SHALL cover: wb_rst_i pulsed asynchronously mid-frame at level=5 -> outputs 0 immediately, s_tready=1 after release, next frame's m_tlast on beat data_length.
